// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;
  localparam int          ITER   = 32;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_nxt,
  output logic             qbit
);

  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   diff;

  always_comb begin
    trial   = {rem, dbit};
    qbit    = (trial >= {2'b00, divisor});
    // When the subtraction is taken the result is below the divisor, so the low bits suffice.
    diff    = trial[WIDTH:0] - {1'b0, divisor};
    rem_nxt = qbit ? diff : trial[WIDTH:0];
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and direct MTHI/MTLO writes.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               is_mul;
  logic               neg_q;
  logic               neg_r;
  logic               div0;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;

  logic               sa;
  logic               sb;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_nxt;
  logic               qbit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic s);
    return s ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if_w(input logic [2*WIDTH-1:0] v, input logic s);
    return s ? (~v + 1'b1) : v;
  endfunction

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem     (rem),
    .dbit    (opa[WIDTH-1]),
    .divisor (opb),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  always_comb begin
    // Unsigned ops (op[0]=1) never see a sign; magnitude of 0x80000000 stays 0x80000000.
    sa       = ~op[0] & a[WIDTH-1];
    sb       = ~op[0] & b[WIDTH-1];
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);
    prod_fix = neg_if_w(acc, neg_q);
    quo_fix  = div0 ? DIV0_Q : neg_if(acc[WIDTH-1:0], neg_q);
    rem_fix  = neg_if(rem[WIDTH-1:0], neg_r);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      rem    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                opa    <= neg_if(a, sa);
                opb    <= neg_if(b, sb);
                is_mul <= ~op[1];
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                div0   <= (b == '0);
                acc    <= '0;
                rem    <= '0;
                cnt    <= '0;
                state  <= CALC;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        CALC: begin
          if (is_mul) begin
            // Shift-add: add multiplicand into the upper half, then shift the whole product right.
            acc <= {sum, acc[WIDTH-1:1]};
            opb <= opb >> 1;
          end else begin
            acc <= {acc[2*WIDTH-2:0], qbit};
            rem <= rem_nxt;
            opa <= opa << 1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= SIGN;
        end
        SIGN: begin
          if (is_mul) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CALC) || (state == SIGN);
  assign done = (state == DONE);

endmodule
